// File: rtl/seqdet_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// Included first so the detector and its counter see one definition.
package seqdet_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment.
module seqdet_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] r_count;

  assign count = r_count;
  assign sat   = &r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !sat) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial bit-pattern detector.
// Mealy match flag, registered copy, saturating match count.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic               match_q,
  input  logic               count_clr,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic               armed
);

  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_err;
  logic               r_match_q;

  logic [MAX_LEN-1:0] w_cat;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic               w_match;
  logic               w_legal;
  logic [LEN_W-1:0]   w_lenm1;
  logic [LEN_W-1:0]   w_fill_nx;

  assign w_cat     = {r_hist, in_bit};
  assign w_legal   = (cfg_len != '0) && (cfg_len <= L_MAX);
  assign w_lenm1   = r_len - L_ONE;
  assign w_fill_nx = r_fill + L_ONE;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (r_len > LEN_W'(i));
    end
  end

  // Bits at or above the programmed length never block a match.
  assign w_hit   = &(~(w_cat ^ r_pat) | ~w_mask);
  assign w_match = in_valid && (r_state == RUN) && w_hit;

  assign match   = w_match;
  assign match_q = r_match_q;
  assign cfg_err = r_err;
  assign armed   = (r_state == RUN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= UNCFG;
      r_pat     <= '0;
      r_len     <= '0;
      r_ovl     <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_err     <= 1'b0;
      r_match_q <= 1'b0;
    end else begin
      r_match_q <= w_match;
      if (cfg_load) begin
        r_hist <= '0;
        r_fill <= '0;
        if (w_legal) begin
          r_pat   <= cfg_pattern;
          r_len   <= cfg_len;
          r_ovl   <= cfg_overlap;
          r_err   <= 1'b0;
          r_state <= (cfg_len == L_ONE) ? RUN : FILL;
        end else begin
          r_pat   <= '0;
          r_len   <= '0;
          r_ovl   <= 1'b0;
          r_err   <= 1'b1;
          r_state <= UNCFG;
        end
      end else if (in_valid && (r_state != UNCFG)) begin
        r_hist <= w_cat[MAX_LEN-2:0];
        if (w_match && !r_ovl) begin
          r_fill  <= '0;
          r_state <= (r_len == L_ONE) ? RUN : FILL;
        end else if (r_state == FILL) begin
          r_fill <= w_fill_nx;
          if (w_fill_nx == w_lenm1) begin
            r_state <= RUN;
          end
        end
      end
    end
  end

  seqdet_sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (w_match),
    .clr    (count_clr | cfg_load),
    .count  (match_count),
    .sat    (count_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed-vector bench for seq_detector_param.
// Two instances share stimulus: 8-bit and 2-bit match counters.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_load = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       count_clr = 1'b0;

  logic       cfg_err, match, match_q, count_sat, armed;
  logic [7:0] match_count;
  logic       cfg_err2, match2, match_q2, count_sat2, armed2;
  logic [1:0] match_count2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_bit(in_bit), .match(match),
    .match_q(match_q), .count_clr(count_clr),
    .match_count(match_count), .count_sat(count_sat),
    .armed(armed)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
    .in_valid(in_valid), .in_bit(in_bit), .match(match2),
    .match_q(match_q2), .count_clr(count_clr),
    .match_count(match_count2), .count_sat(count_sat2),
    .armed(armed2)
  );

  typedef struct {
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       vld;
    logic       b;
    logic       clr;
    logic       m;
    int         cnt;
    logic       arm;
    logic       err;
  } vec_t;

  vec_t vq[$];
  logic cur_err = 1'b0;

  function automatic void L(logic [7:0] pat, logic [3:0] len,
                            logic ov, logic vld, logic b,
                            logic arm, logic err);
    vec_t v;
    v.ld = 1'b1; v.pat = pat; v.len = len; v.ov = ov;
    v.vld = vld; v.b = b; v.clr = 1'b0; v.m = 1'b0;
    v.cnt = 0; v.arm = arm; v.err = err;
    cur_err = err;
    vq.push_back(v);
  endfunction

  function automatic void B(logic b, logic clr, logic m,
                            int cnt, logic arm);
    vec_t v;
    v.ld = 1'b0; v.pat = '0; v.len = '0; v.ov = 1'b0;
    v.vld = 1'b1; v.b = b; v.clr = clr; v.m = m;
    v.cnt = cnt; v.arm = arm; v.err = cur_err;
    vq.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".match"},   32'(match),       0);
    chk({tag, ".match_q"}, 32'(match_q),     0);
    chk({tag, ".count"},   32'(match_count), 0);
    chk({tag, ".sat"},     32'(count_sat),   0);
    chk({tag, ".armed"},   32'(armed),       0);
    chk({tag, ".err"},     32'(cfg_err),     0);
    chk({tag, ".count2"},  32'(match_count2), 0);
  endtask

  initial begin
    int   c2;
    logic [7:0] bits;

    // 1: 11011 overlapping
    L(8'h1B, 5, 1, 0, 0, 0, 0);
    B(1,0,0,0,0); B(1,0,0,0,0); B(0,0,0,0,0); B(1,0,0,0,1);
    B(1,0,1,1,1); B(0,0,0,1,1); B(1,0,0,1,1); B(1,0,1,2,1);
    // 2: 11011 non-overlapping, stream 1101101111011
    L(8'h1B, 5, 0, 0, 0, 0, 0);
    B(1,0,0,0,0); B(1,0,0,0,0); B(0,0,0,0,0); B(1,0,0,0,1);
    B(1,0,1,1,0); B(0,0,0,1,0); B(1,0,0,1,0); B(1,0,0,1,0);
    B(1,0,0,1,1); B(1,0,0,1,1); B(0,0,0,1,1); B(1,0,0,1,1);
    B(1,0,1,2,0);
    // 3: single-bit pattern
    L(8'h01, 1, 0, 0, 0, 1, 0);
    B(1,0,1,1,1); B(0,0,0,1,1); B(1,0,1,2,1); B(1,0,1,3,1);
    // 4: illegal lengths, then legal load with junk above len
    L(8'h1B, 0, 1, 0, 0, 0, 1);
    B(1,0,0,0,0); B(1,0,0,0,0);
    L(8'h1B, 9, 1, 0, 0, 0, 1);
    B(1,0,0,0,0);
    L(8'hFB, 5, 1, 0, 0, 0, 0);
    B(1,0,0,0,0); B(1,0,0,0,0); B(0,0,0,0,0); B(1,0,0,0,1);
    B(1,0,1,1,1);
    // 5: saturation on the 2-bit instance, clear beats match
    L(8'h01, 1, 1, 0, 0, 1, 0);
    B(1,0,1,1,1); B(1,0,1,2,1); B(1,0,1,3,1); B(1,0,1,4,1);
    B(1,0,1,5,1); B(1,1,1,0,1); B(1,0,1,1,1); B(0,0,0,1,1);
    // reload with a valid bit mid-pattern: bit dropped, FILL restarts
    L(8'h1B, 5, 1, 0, 0, 0, 0);
    B(1,0,0,0,0); B(1,0,0,0,0); B(0,0,0,0,0);
    L(8'h1B, 5, 1, 1, 1, 0, 0);
    B(1,0,0,0,0); B(0,0,0,0,0); B(1,0,0,0,0); B(1,0,0,0,1);

    #2;
    chk_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      cfg_load    = vq[i].ld;
      cfg_pattern = vq[i].pat;
      cfg_len     = vq[i].len;
      cfg_overlap = vq[i].ov;
      in_valid    = vq[i].vld;
      in_bit      = vq[i].b;
      count_clr   = vq[i].clr;
      #1;
      chk($sformatf("v%0d.match", i), 32'(match), 32'(vq[i].m));
      @(posedge clk);
      #1;
      c2 = (vq[i].cnt > 3) ? 3 : vq[i].cnt;
      chk($sformatf("v%0d.match_q", i), 32'(match_q), 32'(vq[i].m));
      chk($sformatf("v%0d.count", i), 32'(match_count), vq[i].cnt);
      chk($sformatf("v%0d.sat", i), 32'(count_sat),
          32'(vq[i].cnt == 255));
      chk($sformatf("v%0d.armed", i), 32'(armed), 32'(vq[i].arm));
      chk($sformatf("v%0d.err", i), 32'(cfg_err), 32'(vq[i].err));
      chk($sformatf("v%0d.count2", i), 32'(match_count2), c2);
      chk($sformatf("v%0d.sat2", i), 32'(count_sat2), 32'(c2 == 3));
    end

    // 6: asynchronous reset right after a match
    @(negedge clk);
    cfg_load = 1'b1; cfg_pattern = 8'h1B; cfg_len = 4'd5;
    cfg_overlap = 1'b1; in_valid = 1'b0; count_clr = 1'b0;
    @(negedge clk);
    cfg_load = 1'b0;
    bits = 8'b1101_1011;
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit = bits[k];
    end
    @(posedge clk);
    #1;
    chk("pre_rst.match_q", 32'(match_q), 1);
    chk("pre_rst.count", 32'(match_count), 2);
    chk("pre_rst.armed", 32'(armed), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    reset_n = 1'b1;
    bits = 8'b0001_1011;
    for (int k = 4; k >= 0; k--) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit = bits[k];
      #1;
      chk($sformatf("post_rst.match%0d", k), 32'(match), 0);
    end
    @(posedge clk);
    #1;
    chk("post_rst.count", 32'(match_count), 0);
    chk("post_rst.armed", 32'(armed), 0);
    chk("post_rst.match_q", 32'(match_q), 0);
    @(negedge clk);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
